// File: rtl/rom_boot_loader_pkg.sv
// Shared types and constants for the boot ROM loader: FSM state, image
// parsing phase, error codes, the image magic word and checksum helper.
package rom_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PH_MAGIC = 2'd0,
    PH_LEN   = 2'd1,
    PH_DATA  = 2'd2,
    PH_CSUM  = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_MAGIC   = 3'd1,
    ERR_LEN     = 3'd2,
    ERR_CSUM    = 3'd3,
    ERR_TIMEOUT = 3'd4
  } err_t;

  localparam logic [31:0] BOOT_MAGIC  = 32'hB007_C0DE;
  localparam int          ROM_ADDR_W  = 15;
  localparam int          DEF_SRAM_AW = 14;

  // Additive image checksum: running sum of payload words, wrapping mod 2^32.
  function automatic logic [31:0] csum_add(input logic [31:0] sum, input logic [31:0] word);
    return sum + word;
  endfunction

endpackage

// File: rtl/rom_boot_loader_if.sv
// Boot ROM read port and SRAM write port seen by the loader. The loader is
// the master on both; the ROM controller / SRAM side uses the slave view.
interface rom_boot_loader_if #(
  parameter int SRAM_AW = 14
) ();
  import rom_boot_loader_pkg::*;

  logic                  rom_req;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [31:0]           rom_rdata;
  logic                  rom_ready;
  logic                  sram_we;
  logic [SRAM_AW-1:0]    sram_addr;
  logic [31:0]           sram_wdata;
  logic                  sram_ack;

  modport master (
    output rom_req, rom_addr, sram_we, sram_addr, sram_wdata,
    input  rom_rdata, rom_ready, sram_ack
  );

  modport slave (
    input  rom_req, rom_addr, sram_we, sram_addr, sram_wdata,
    output rom_rdata, rom_ready, sram_ack
  );
endinterface

// File: rtl/rom_boot_loader.sv
// Boot-time loader: reads an image from the boot ROM one word at a time,
// validates magic and length, copies the payload into SRAM and verifies an
// additive checksum. Only one ROM read is ever outstanding and no ROM read
// is issued while an SRAM write is pending. All outputs are registered.
module rom_boot_loader
  import rom_boot_loader_pkg::*;
#(
  parameter int                 ROM_WORDS   = 8192,
  parameter int                 SRAM_AW     = DEF_SRAM_AW,
  parameter logic [SRAM_AW-1:0] DEST_BASE   = 14'h0000,
  parameter int                 TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  rom_boot_loader_if.master   bus,
  output logic                boot_busy,
  output logic                boot_done,
  output logic                boot_fail,
  output logic [2:0]          boot_err
);

  localparam int              IDX_W    = ROM_ADDR_W - 2;
  localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [31:0]     LEN_MAX  = 32'(ROM_WORDS - 3);

  state_t              state_r;
  phase_t              phase_r;
  err_t                err_r;
  logic [IDX_W-1:0]    idx_r;
  logic [IDX_W-1:0]    cnt_r;
  logic [IDX_W-1:0]    len_r;
  logic [31:0]         sum_r;
  logic [TMO_W-1:0]    tmo_r;
  logic                busy_r;
  logic                done_r;
  logic                fail_r;
  logic                rom_req_r;
  logic [ROM_ADDR_W-1:0] rom_addr_r;
  logic                sram_we_r;
  logic [SRAM_AW-1:0]  sram_addr_r;
  logic [31:0]         sram_wdata_r;
  logic [IDX_W-1:0]    idx_next_s;

  assign idx_next_s     = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};

  assign bus.rom_req    = rom_req_r;
  assign bus.rom_addr   = rom_addr_r;
  assign bus.sram_we    = sram_we_r;
  assign bus.sram_addr  = sram_addr_r;
  assign bus.sram_wdata = sram_wdata_r;
  assign boot_busy      = busy_r;
  assign boot_done      = done_r;
  assign boot_fail      = fail_r;
  assign boot_err       = err_r;

  // Loader FSM: sequences ROM reads, image checks, SRAM writes and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      phase_r      <= PH_MAGIC;
      err_r        <= ERR_NONE;
      idx_r        <= '0;
      cnt_r        <= '0;
      len_r        <= '0;
      sum_r        <= 32'h0000_0000;
      tmo_r        <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      fail_r       <= 1'b0;
      rom_req_r    <= 1'b0;
      rom_addr_r   <= '0;
      sram_we_r    <= 1'b0;
      sram_addr_r  <= '0;
      sram_wdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            state_r    <= ST_REQ;
            phase_r    <= PH_MAGIC;
            err_r      <= ERR_NONE;
            idx_r      <= '0;
            cnt_r      <= '0;
            len_r      <= '0;
            sum_r      <= 32'h0000_0000;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            fail_r     <= 1'b0;
            rom_req_r  <= 1'b1;
            rom_addr_r <= '0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_REQ: begin
          // The request pulse lasts exactly this one cycle.
          rom_req_r <= 1'b0;
          tmo_r     <= '0;
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.rom_ready) begin
            tmo_r <= '0;
            case (phase_r)
              PH_MAGIC: begin
                if (bus.rom_rdata != BOOT_MAGIC) begin
                  state_r <= ST_FAIL;
                  busy_r  <= 1'b0;
                  fail_r  <= 1'b1;
                  err_r   <= ERR_MAGIC;
                end else begin
                  idx_r      <= idx_next_s;
                  phase_r    <= PH_LEN;
                  rom_req_r  <= 1'b1;
                  rom_addr_r <= {idx_next_s, 2'b00};
                  state_r    <= ST_REQ;
                end
              end
              PH_LEN: begin
                // Upper bits must be clear and magic+len+csum must fit in ROM.
                if ((|bus.rom_rdata[31:IDX_W]) || (bus.rom_rdata > LEN_MAX)) begin
                  state_r <= ST_FAIL;
                  busy_r  <= 1'b0;
                  fail_r  <= 1'b1;
                  err_r   <= ERR_LEN;
                end else begin
                  len_r      <= bus.rom_rdata[IDX_W-1:0];
                  phase_r    <= (bus.rom_rdata == 32'h0000_0000) ? PH_CSUM : PH_DATA;
                  idx_r      <= idx_next_s;
                  rom_req_r  <= 1'b1;
                  rom_addr_r <= {idx_next_s, 2'b00};
                  state_r    <= ST_REQ;
                end
              end
              PH_DATA: begin
                sum_r        <= csum_add(sum_r, bus.rom_rdata);
                sram_we_r    <= 1'b1;
                sram_addr_r  <= DEST_BASE + SRAM_AW'(cnt_r);
                sram_wdata_r <= bus.rom_rdata;
                state_r      <= ST_WRITE;
              end
              PH_CSUM: begin
                busy_r <= 1'b0;
                if (sum_r == bus.rom_rdata) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
                end else begin
                  state_r <= ST_FAIL;
                  fail_r  <= 1'b1;
                  err_r   <= ERR_CSUM;
                end
              end
              default: begin
                state_r <= ST_FAIL;
                busy_r  <= 1'b0;
                fail_r  <= 1'b1;
                err_r   <= ERR_TIMEOUT;
              end
            endcase
          end else if (tmo_r == TMO_LAST) begin
            state_r <= ST_FAIL;
            busy_r  <= 1'b0;
            fail_r  <= 1'b1;
            err_r   <= ERR_TIMEOUT;
          end else begin
            tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
          end
        end
        ST_WRITE: begin
          // Address/data stay frozen until the SRAM accepts the word.
          if (bus.sram_ack) begin
            sram_we_r  <= 1'b0;
            cnt_r      <= cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
            idx_r      <= idx_next_s;
            phase_r    <= ((cnt_r + {{(IDX_W-1){1'b0}}, 1'b1}) == len_r) ? PH_CSUM : PH_DATA;
            rom_req_r  <= 1'b1;
            rom_addr_r <= {idx_next_s, 2'b00};
            state_r    <= ST_REQ;
          end else begin
            state_r <= ST_WRITE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          rom_req_r <= 1'b0;
          sram_we_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
